leaf_uplink_arbiter: RTL

LEAF_UPLINK_ARBITER -- requirements
Module: leaf_uplink_arbiter

---
 rtl/leaf_uplink_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/leaf_uplink_arbiter.sv
// Leaf-to-spine uplink: per-source FIFOs, round-robin arbiter, credit-based flow control.
// Optional flit statistics counter enabled by defining LEAF_UPLINK_STATS_EN.
module leaf_uplink_arbiter #(
    parameter int DWIDTH     = 16,
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*DWIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [DWIDTH-1:0]           up_data,
    output logic                        up_valid,
    input  logic                        up_credit,
    output logic [3:0]                  credit_cnt,
    output logic                        err_credit
`ifdef LEAF_UPLINK_STATS_EN
    ,
    output logic [15:0]                 flit_count
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Handshake: a source flit transfers on a rising edge where src_valid[i] && src_ready[i];
    // up_valid is a one-cycle strobe with no back-pressure, throttled only by credit_cnt.

    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [NUM_SRC-1:0] w_nonempty;
    logic [DWIDTH-1:0]  w_head [NUM_SRC];

    logic [IW:0]        w_pick;
    logic               w_grant;
    logic [IW-1:0]      w_grant_idx;
    logic [IW-1:0]      w_rr_next;

    logic [IW-1:0]      r_rr_ptr;
    logic [DWIDTH-1:0]  r_up_data;
    logic               r_up_valid;
    logic [3:0]         r_credit_cnt;
    logic               r_err_credit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gen_fifo
        logic [PW-1:0]     r_wr_ptr;
        logic [PW-1:0]     r_rd_ptr;
        logic [CW-1:0]     r_count;
        logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];

        assign src_ready[i]  = (r_count != CW'(FIFO_DEPTH));
        assign w_nonempty[i] = (r_count != '0);
        assign w_push[i]     = src_valid[i] & src_ready[i];
        assign w_pop[i]      = w_grant && (w_grant_idx == IW'(i));
        assign w_head[i]     = r_mem[r_rd_ptr];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[i]) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop[i])  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        // Storage needs no reset: the cleared pointers and count make stale entries unreachable.
        always_ff @(posedge clk) begin
            if (w_push[i]) r_mem[r_wr_ptr] <= src_data[i*DWIDTH +: DWIDTH];
        end
    end

    // First non-empty source at or after start; MSB flags that one was found.
    function automatic logic [IW:0] rr_pick(input logic [NUM_SRC-1:0] ne, input logic [IW-1:0] start);
        logic [IW:0] sel;
        int          c;
        sel = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            c = int'(start) + k;
            if (c >= NUM_SRC) c = c - NUM_SRC;
            if (ne[c[IW-1:0]]) sel = {1'b1, c[IW-1:0]};
        end
        return sel;
    endfunction

    assign w_pick      = rr_pick(w_nonempty, r_rr_ptr);
    assign w_grant_idx = w_pick[IW-1:0];
    assign w_grant     = w_pick[IW] && (r_credit_cnt != '0);
    assign w_rr_next   = (w_grant_idx == IW'(NUM_SRC - 1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_up_data    <= '0;
            r_up_valid   <= 1'b0;
            r_credit_cnt <= 4'(CREDITS);
            r_err_credit <= 1'b0;
        end else begin
            r_up_valid <= w_grant;
            if (w_grant) begin
                r_up_data <= w_head[w_grant_idx];
                r_rr_ptr  <= w_rr_next;
            end
            case ({w_grant, up_credit})
                2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
                2'b01: begin
                    // A return beyond the spine FIFO depth means the peer miscounted.
                    if (r_credit_cnt == 4'(CREDITS)) r_err_credit <= 1'b1;
                    else                             r_credit_cnt <= r_credit_cnt + 1'b1;
                end
                default: r_credit_cnt <= r_credit_cnt;
            endcase
        end
    end

`ifdef LEAF_UPLINK_STATS_EN
    logic [15:0] r_flit_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_flit_count <= '0;
        else if (w_grant) r_flit_count <= r_flit_count + 16'd1;
    end

    assign flit_count = r_flit_count;
`endif

    assign up_data    = r_up_data;
    assign up_valid   = r_up_valid;
    assign credit_cnt = r_credit_cnt;
    assign err_credit = r_err_credit;

endmodule
